// File: rtl/gf16_sqrt_seq_if.sv
// Handshake bundle between the GF(2^4) square-root unit and its neighbours.
// master = operand producer / result consumer, slave = the unit itself.
interface gf16_sqrt_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_check;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_check
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_check
  );
endinterface

// File: rtl/gf16_sqrt_seq.sv
// Sequential GF(2^4) root unit (P = x^4+x^3+1): result = a^(2^ITER) by ITER squarings, plus self-check.
// Latency: operand accepted at edge k, result valid after edge k+ITER+1.
// Backpressure: result held stable in DONE until out_ready; no new operand accepted until back in IDLE.
module gf16_sqrt_seq #(
  parameter int ITER = 3
) (
  input  logic           clk,
  input  logic           rst,
  gf16_sqrt_seq_if.slave bus,
  output logic           busy
);

  if (ITER < 1 || ITER > 7) begin : g_bad_iter
    $error("gf16_sqrt_seq: ITER must be in 1..7");
  end

  typedef enum logic [1:0] {IDLE, BUSY, VERIFY, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] op_r;
  logic [3:0] acc_r;
  logic [2:0] cnt_r;
  logic       chk_r;
  logic [3:0] sq_acc;
  logic       load;
  logic       step;
  logic       verify;

  // Modular square: x^4 = x^3+1, x^5 = x^3+x+1, x^6 = x^3+x^2+x+1 folded into the low bits.
  function automatic logic [3:0] sq(input logic [3:0] b);
    return {b[2] ^ b[3], b[1] ^ b[3], b[3], b[0] ^ b[2] ^ b[3]};
  endfunction

  // Single squarer shared by the iteration and the verify step.
  assign sq_acc = sq(acc_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    step          = 1'b0;
    verify        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_r == 3'd1) state_nxt = VERIFY;
      end
      VERIFY: begin
        verify    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operand, iterate squarings, latch the check flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r  <= 4'h0;
      acc_r <= 4'h0;
      cnt_r <= 3'd0;
      chk_r <= 1'b0;
    end else if (load) begin
      op_r  <= bus.in_data;
      acc_r <= bus.in_data;
      cnt_r <= 3'(ITER);
    end else if (step) begin
      acc_r <= sq_acc;
      cnt_r <= cnt_r - 3'd1;
    end else if (verify) begin
      chk_r <= (sq_acc == op_r);
    end
  end

  // Result comes straight from the working registers; only meaningful in DONE.
  assign bus.out_data  = acc_r;
  assign bus.out_check = chk_r;

endmodule

// File: tb/tb_gf16_sqrt_seq.sv
// Self-checking bench for gf16_sqrt_seq: reference model is generic GF(2^4) multiplication.
// Covers reset, known vectors, all operands, random traffic, backpressure, abort and ITER=1.
module tb_gf16_sqrt_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic busy1;
  int   checks = 0;
  int   errors = 0;

  gf16_sqrt_seq_if bus ();
  gf16_sqrt_seq_if bus1 ();

  gf16_sqrt_seq #(.ITER(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave), .busy(busy));
  gf16_sqrt_seq #(.ITER(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave), .busy(busy1));

  always #5 clk = ~clk;

  // Shift-and-add multiply followed by long-division reduction by x^4+x^3+1.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ ({3'b000, a} << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'h19 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] gf_pow2k(input logic [3:0] a, input int k);
    logic [3:0] r;
    r = a;
    for (int i = 0; i < k; i++) r = gf_mul(r, r);
    return r;
  endfunction

  // Offer one operand on the ITER=3 unit and wait (bounded) for its result.
  task automatic launch(input logic [3:0] a, output int lat, output bit to);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = a;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      bus.in_data = 4'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    to = !bus.out_valid;
  endtask

  task automatic retire();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bus.out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    checks++; if (bus.out_check !== 1'b0) begin errors++; $display("FAIL reset_out_check got %b want 0", bus.out_check); end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 4'h0) begin
      errors++; $display("FAIL idle_after_reset got rdy=%b vld=%b busy=%b data=%h want 1 0 0 0",
                         bus.in_ready, bus.out_valid, busy, bus.out_data);
    end
  endtask

  task automatic test_vectors();
    logic [3:0] ops [4] = '{4'h2, 4'h4, 4'h9, 4'hF};
    logic [3:0] exp [4] = '{4'hE, 4'h2, 4'h4, 4'h8};
    int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i], lat, to);
      checks++; if (to || lat != 4) begin errors++; $display("FAIL vec_latency op=%h got %0d want 4", ops[i], lat); end
      checks++; if (bus.out_data !== exp[i]) begin errors++; $display("FAIL vec_data op=%h got %h want %h", ops[i], bus.out_data, exp[i]); end
      checks++; if (bus.out_check !== 1'b1) begin errors++; $display("FAIL vec_check op=%h got %b want 1", ops[i], bus.out_check); end
      retire();
    end
  endtask

  task automatic test_exhaustive();
    int lat; bit to;
    logic [3:0] r;
    for (int a = 0; a < 16; a++) begin
      launch(4'(a), lat, to);
      r = bus.out_data;
      checks++; if (to) begin errors++; $display("FAIL exh_timeout op=%h got none want out_valid", 4'(a)); end
      checks++; if (r !== gf_pow2k(4'(a), 3)) begin errors++; $display("FAIL exh_data op=%h got %h want %h", 4'(a), r, gf_pow2k(4'(a), 3)); end
      checks++; if (gf_mul(r, r) !== 4'(a)) begin errors++; $display("FAIL exh_root op=%h got sq=%h want %h", 4'(a), gf_mul(r, r), 4'(a)); end
      checks++; if (bus.out_check !== 1'b1) begin errors++; $display("FAIL exh_check op=%h got %b want 1", 4'(a), bus.out_check); end
      retire();
    end
  endtask

  task automatic test_random();
    int lat; bit to;
    logic [3:0] a;
    for (int n = 0; n < 24; n++) begin
      a = 4'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      launch(a, lat, to);
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk);
        #1;
      end
      checks++; if (to || bus.out_data !== gf_pow2k(a, 3) || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL rnd_data op=%h got %h vld=%b want %h vld=1", a, bus.out_data, bus.out_valid, gf_pow2k(a, 3));
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    bit bad;
    launch(4'hF, lat, to);
    bad = to;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'h8 || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL bp_hold got vld=%b data=%h rdy=%b want 1 8 0", bus.out_valid, bus.out_data, bus.in_ready); end
    checks++; if (bus.out_check !== 1'b1) begin errors++; $display("FAIL bp_check got %b want 1", bus.out_check); end
    retire();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got rdy=%b vld=%b busy=%b want 1 0 0", bus.in_ready, bus.out_valid, busy);
    end
  endtask

  task automatic test_abort();
    int lat; bit to;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h9;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %b want 1", busy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 4'h0 || bus.out_check !== 1'b0) begin
      errors++; $display("FAIL abort_reset got rdy=%b vld=%b busy=%b data=%h chk=%b want 1 0 0 0 0",
                         bus.in_ready, bus.out_valid, busy, bus.out_data, bus.out_check);
    end
    @(negedge clk) rst = 1'b0;
    launch(4'h4, lat, to);
    checks++; if (to || lat != 4 || bus.out_data !== 4'h2 || bus.out_check !== 1'b1) begin
      errors++; $display("FAIL abort_next got lat=%0d data=%h chk=%b want 4 2 1", lat, bus.out_data, bus.out_check);
    end
    retire();
  endtask

  task automatic test_iter1();
    int lat;
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 4'h4;
    @(posedge clk);
    #1 bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (lat != 2 || bus1.out_valid !== 1'b1) begin errors++; $display("FAIL it1_latency got %0d want 2", lat); end
    checks++; if (bus1.out_data !== gf_pow2k(4'h4, 1) || bus1.out_data !== 4'h9) begin
      errors++; $display("FAIL it1_data got %h want 9", bus1.out_data);
    end
    checks++; if (bus1.out_check !== (gf_mul(4'h9, 4'h9) == 4'h4)) begin errors++; $display("FAIL it1_check got %b want 0", bus1.out_check); end
    @(negedge clk) bus1.out_ready = 1'b1;
    @(posedge clk);
    #1 bus1.out_ready = 1'b0;
    checks++; if (bus1.in_ready !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL it1_release got rdy=%b busy=%b want 1 0", bus1.in_ready, busy1); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 4'h0;
    bus1.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_exhaustive();
    test_random();
    test_backpressure();
    test_abort();
    test_iter1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf16_sqrt_seq.md
Name: gf16_sqrt_seq

Overview:
- Sequential square-root unit for GF(2^4), field polynomial P(x) = x^4 + x^3 + 1. It is the inverse direction of the team's combinational GF(2^4) squarer.
- Uses sqrt(a) = a^(2^3), i.e. three repeated modular squarings, one per clock.
- After the last squaring it squares the root once more and compares the result against the operand, producing a self-check flag.
- Sits between the GF arithmetic datapath and the controller. It has a valid/ready handshake on both sides and holds one operand at a time.

Parameters:
- ITER, 3: number of squaring iterations. Legal range is 1..7; the result is a^(2^ITER). ITER=3 gives the square root. An out-of-range value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand offered
- in_ready  out  1  unit can accept an operand
- in_data  in  4  operand a, bit i = coefficient of x^i
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_data  out  4  result a^(2^ITER)
- out_check  out  1  1 when out_data squared equals the captured operand
- busy  out  1  high in any state other than IDLE

Behaviour:
- Squaring core: combinational function sq(b), instantiated once internally.
  - Z0 = b0^b2^b3, Z1 = b3, Z2 = b1^b3, Z3 = b2^b3.
  - Derived from x^4 = x^3+1, x^5 = x^3+x+1, x^6 = x^3+x^2+x+1.
- Registers:
  - op_r[3:0]: captured operand.
  - acc_r[3:0]: working value.
  - cnt_r[2:0]: iterations remaining.
  - chk_r: check result.
  - state: IDLE, BUSY, VERIFY, DONE.
- Reset (async, rst=1): state=IDLE, op_r=acc_r=0, cnt_r=0, chk_r=0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_data=0, out_check=0, busy=0.
  - Asserting reset mid-operation aborts the operation immediately; the operand is lost.
- IDLE: in_ready=1.
  - On an edge with in_valid=1: op_r<=in_data, acc_r<=in_data, cnt_r<=ITER, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: in_ready=0. Each edge: acc_r<=sq(acc_r), cnt_r<=cnt_r-1.
  - On the edge where cnt_r==1, go to VERIFY.
  - Exactly ITER squarings occur.
- VERIFY: one cycle. chk_r<=(sq(acc_r)==op_r), then go to DONE. acc_r is unchanged.
- DONE: out_valid=1, out_data=acc_r, out_check=chk_r.
  - Data and flag stay stable while out_ready=0; stalls can be of any length.
  - On an edge with out_ready=1, go to IDLE.
  - No new operand is accepted on that same edge, because in_ready=0 in DONE.
  - in_ready rises the following cycle.
- out_data and out_check are registered and driven only from acc_r and chk_r.
  - Their values outside DONE are don't-care for consumers, but must be deterministic: hold the last computed value, or 0 after reset.
- Latency: accept edge k, then out_valid is high after edge k+ITER+1 (4 cycles for ITER=3).
  - Throughput is one result per ITER+3 cycles when out_ready=1.
- in_data changing while not in IDLE has no effect.
- Operands 0 and 1 are fixed points (their result equals the input).
- With ITER=3, out_check must be 1 for every operand. A 0 indicates a datapath fault, and the unit does not otherwise act on it.

Test Plan:
- Reset then idle: assert rst mid-cycle (asynchronously), release, hold in_valid=0 -> in_ready=1, out_valid=0, busy=0, out_data=0.
- Single op, ITER=3: in_data=0x2 accepted at edge k -> out_valid at k+4, out_data=0xE, out_check=1. Also cover 0x4->0x2, 0x9->0x4, 0xF->0x8.
- Exhaustive: all 16 operands with out_ready=1 -> sq(out_data)==in_data every time, out_check=1. 0x0->0x0 and 0x1->0x1.
- Backpressure: in_data=0xF, hold out_ready=0 for 10 cycles -> out_valid stays 1, out_data=0x8 stable, in_ready=0. After out_ready=1 at one edge -> IDLE next cycle, in_ready=1.
- Abort: accept 0x9, assert rst during BUSY -> outputs return to reset values immediately. Next operand 0x4 -> 0x2 with correct latency.
- Parameter: ITER=1, in_data=0x4 -> out_data=0x9 after 2 cycles, out_check=0.
